// File: rtl/sd_cmd_pkg.sv
// rtl/sd_cmd_pkg.sv - frame lengths, CRC7 polynomial, FSM encoding and CRC7 step for the SD CMD responder
package sd_cmd_pkg;

  localparam int CMD_FRAME_LEN    = 48;
  localparam int R2_FRAME_LEN     = 136;
  localparam int CRC_BITS_COVERED = 40;
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RECEIVE    = 3'd1,
    CHECK      = 3'd2,
    WAIT_RESP  = 3'd3,
    TURNAROUND = 3'd4,
    SEND       = 3'd5,
    DONE       = 3'd6
  } state_t;

  // One serial step of x^7 + x^3 + 1, message bit entering at the top.
  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic data_bit);
    logic feedback;
    feedback = crc[6] ^ data_bit;
    return {crc[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_card_cmd_responder_if.sv
// rtl/sd_card_cmd_responder_if.sv - card-logic side of the SD CMD responder: command report and response offer
interface sd_card_cmd_responder_if;

  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic         cmd_valid;
  logic         crc_error;
  logic         resp_strobe;
  logic         resp_long;
  logic [135:0] resp_data;
  logic         resp_ack;
  logic         resp_done;
  logic         resp_timeout;

  modport master (
    input  cmd_index, cmd_arg, cmd_valid, crc_error, resp_ack, resp_done, resp_timeout,
    output resp_strobe, resp_long, resp_data
  );

  modport slave (
    output cmd_index, cmd_arg, cmd_valid, crc_error, resp_ack, resp_done, resp_timeout,
    input  resp_strobe, resp_long, resp_data
  );

endinterface

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 accumulator; clear with enable restarts the sum on the current bit
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       sd_clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_bit,
  output logic [6:0] crc
);

  logic [6:0] seed;

  assign seed = clear ? 7'd0 : crc;

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      crc <= 7'd0;
    end else if (enable) begin
      crc <= crc7_next(seed, data_bit);
    end else if (clear) begin
      crc <= 7'd0;
    end
  end

endmodule

// File: rtl/sd_card_cmd_responder.sv
// rtl/sd_card_cmd_responder.sv - receives 48-bit SD commands on CMD, checks CRC7, and drives 48/136-bit responses
module sd_card_cmd_responder
  import sd_cmd_pkg::*;
#(
  parameter int NCR          = 2,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic                   sd_clock,
  input  logic                   reset,
  input  logic                   cmd_in,
  output logic                   cmd_out,
  output logic                   cmd_oe,
  sd_card_cmd_responder_if.slave bus
);

  // Start bit is consumed in IDLE, so RECEIVE sees bits 46..0.
  localparam logic [7:0] RX_LAST       = 8'(CMD_FRAME_LEN - 2);
  localparam logic [7:0] RX_CRC_BITS   = 8'(CRC_BITS_COVERED - 1);
  localparam logic [7:0] TX_CRC_BITS   = 8'(CRC_BITS_COVERED);
  localparam logic [7:0] TX_SHORT_END  = 8'(CMD_FRAME_LEN - 1);
  localparam logic [7:0] TX_LONG_END   = 8'(R2_FRAME_LEN - 1);
  localparam logic [7:0] TIMEOUT_LAST  = 8'(RESP_TIMEOUT - 1);
  localparam logic [7:0] NCR_LAST      = 8'(NCR - 1);

  state_t       state, state_d;
  logic [7:0]   cnt;
  logic [46:0]  rx_shift;
  logic [135:0] tx_shift;
  logic         resp_long_q;
  logic [5:0]   cmd_index_q;
  logic [31:0]  cmd_arg_q;
  logic         cmd_valid_q, crc_error_q, resp_ack_q, resp_done_q, resp_timeout_q;
  logic         cmd_valid_d, crc_error_d, resp_ack_d, resp_done_d, resp_timeout_d;
  logic         capture, accept_cmd;
  logic         rx_crc_clear, rx_crc_en, tx_crc_clear, tx_crc_en;
  logic [6:0]   rx_crc, tx_crc;
  logic         rx_ok, tx_bit;
  logic [7:0]   tx_last;

  sd_crc7 u_rx_crc (
    .sd_clock (sd_clock),
    .reset    (reset),
    .clear    (rx_crc_clear),
    .enable   (rx_crc_en),
    .data_bit (cmd_in),
    .crc      (rx_crc)
  );

  sd_crc7 u_tx_crc (
    .sd_clock (sd_clock),
    .reset    (reset),
    .clear    (tx_crc_clear),
    .enable   (tx_crc_en),
    .data_bit (tx_shift[135]),
    .crc      (tx_crc)
  );

  assign rx_ok   = rx_shift[46] && rx_shift[0] && (rx_crc == rx_shift[7:1]);
  assign tx_last = resp_long_q ? TX_LONG_END : TX_SHORT_END;

  // Short responses replace the caller's CRC field and force the end bit.
  always_comb begin
    if (resp_long_q || cnt < TX_CRC_BITS) begin
      tx_bit = tx_shift[135];
    end else if (cnt < TX_SHORT_END) begin
      tx_bit = tx_crc[3'd6 - cnt[2:0]];
    end else begin
      tx_bit = 1'b1;
    end
  end

  always_comb begin
    state_d        = state;
    rx_crc_clear   = 1'b0;
    rx_crc_en      = 1'b0;
    tx_crc_clear   = 1'b0;
    tx_crc_en      = 1'b0;
    capture        = 1'b0;
    accept_cmd     = 1'b0;
    cmd_valid_d    = 1'b0;
    crc_error_d    = 1'b0;
    resp_ack_d     = 1'b0;
    resp_done_d    = 1'b0;
    resp_timeout_d = 1'b0;
    cmd_oe         = 1'b0;
    cmd_out        = 1'b1;
    case (state)
      IDLE: begin
        rx_crc_clear = 1'b1;
        rx_crc_en    = ~cmd_in;
        if (!cmd_in) state_d = RECEIVE;
      end
      RECEIVE: begin
        rx_crc_en = (cnt < RX_CRC_BITS);
        if (cnt == 8'd0 && !cmd_in) begin
          state_d = IDLE;
        end else if (cnt == RX_LAST) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (rx_ok) begin
          accept_cmd  = 1'b1;
          cmd_valid_d = 1'b1;
          state_d     = WAIT_RESP;
        end else begin
          crc_error_d = 1'b1;
          state_d     = IDLE;
        end
      end
      WAIT_RESP: begin
        if (bus.resp_strobe) begin
          capture    = 1'b1;
          resp_ack_d = 1'b1;
          state_d    = TURNAROUND;
        end else if (cnt == TIMEOUT_LAST) begin
          resp_timeout_d = 1'b1;
          state_d        = IDLE;
        end
      end
      TURNAROUND: begin
        cmd_oe       = 1'b1;
        tx_crc_clear = 1'b1;
        if (cnt == NCR_LAST) state_d = SEND;
      end
      SEND: begin
        cmd_oe    = 1'b1;
        cmd_out   = tx_bit;
        tx_crc_en = !resp_long_q && (cnt < TX_CRC_BITS);
        if (cnt == tx_last) begin
          resp_done_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      rx_shift       <= '0;
      tx_shift       <= '0;
      resp_long_q    <= 1'b0;
      cmd_index_q    <= 6'd0;
      cmd_arg_q      <= 32'd0;
      cmd_valid_q    <= 1'b0;
      crc_error_q    <= 1'b0;
      resp_ack_q     <= 1'b0;
      resp_done_q    <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= (state_d != state) ? 8'd0 : cnt + 8'd1;
      if (state == RECEIVE) rx_shift <= {rx_shift[45:0], cmd_in};
      if (capture) begin
        tx_shift    <= bus.resp_long ? bus.resp_data : {bus.resp_data[47:0], 88'd0};
        resp_long_q <= bus.resp_long;
      end else if (state == SEND) begin
        tx_shift <= {tx_shift[134:0], 1'b0};
      end
      if (accept_cmd) begin
        cmd_index_q <= rx_shift[45:40];
        cmd_arg_q   <= rx_shift[39:8];
      end
      cmd_valid_q    <= cmd_valid_d;
      crc_error_q    <= crc_error_d;
      resp_ack_q     <= resp_ack_d;
      resp_done_q    <= resp_done_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  assign bus.cmd_index    = cmd_index_q;
  assign bus.cmd_arg      = cmd_arg_q;
  assign bus.cmd_valid    = cmd_valid_q;
  assign bus.crc_error    = crc_error_q;
  assign bus.resp_ack     = resp_ack_q;
  assign bus.resp_done    = resp_done_q;
  assign bus.resp_timeout = resp_timeout_q;

endmodule

// File: doc/sd_card_cmd_responder.md
SD_CARD_CMD_RESPONDER -- requirements
Module: sd_card_cmd_responder

Interface
REQ-001 Parameter NCR, default 2, idle-high cycles driven between response acceptance and response start bit.
REQ-002 Parameter RESP_TIMEOUT, default 64, sd_clock cycles allowed between cmd_valid and resp_strobe.
REQ-003 sd_clock  in  1  single clock; all logic on posedge. One clock; reset is synchronous and active-high.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_in  in  1  serial CMD line from host, MSB first.
REQ-006 cmd_out  out  1  serial response bit to CMD line.
REQ-007 cmd_oe  out  1  CMD pad drive enable.
REQ-008 cmd_index  out  6  received command index.
REQ-009 cmd_arg  out  32  received command argument.
REQ-010 cmd_valid  out  1  one-cycle pulse: frame received, CRC and end bit good.
REQ-011 crc_error  out  1  one-cycle pulse: CRC7 mismatch or end bit 0.
REQ-012 resp_strobe  in  1  card logic offers a response.
REQ-013 resp_long  in  1  1 = 136-bit R2, 0 = 48-bit response.
REQ-014 resp_data  in  136  response frame content, MSB first.
REQ-015 resp_ack  out  1  one-cycle pulse: resp_data captured.
REQ-016 resp_done  out  1  one-cycle pulse: last response bit driven.
REQ-017 resp_timeout  out  1  one-cycle pulse: no resp_strobe within RESP_TIMEOUT.

Function
REQ-018 States SHALL be IDLE, RECEIVE, CHECK, WAIT_RESP, TURNAROUND, SEND, DONE.
REQ-019 IDLE: cmd_in sampled 0 SHALL enter RECEIVE; cmd_in 1 stays in IDLE.
REQ-020 RECEIVE SHALL shift 47 further bits (48-bit frame: start 0, transmission 1, index 6, arg 32, CRC7, end 1).
REQ-021 If the transmission bit is 0 (another device's response), the FSM SHALL discard the frame and return to IDLE with no pulse.
REQ-022 CRC7 (x^7+x^3+1, init 0) SHALL cover frame bits 47..8 and be compared with bits 7..1.
REQ-023 CHECK, one cycle after end bit: pass -> cmd_index/cmd_arg updated and cmd_valid pulsed, then WAIT_RESP; fail -> crc_error pulsed, outputs held, then IDLE.
REQ-024 WAIT_RESP: resp_strobe high SHALL capture resp_data/resp_long, pulse resp_ack the next cycle, and enter TURNAROUND.
REQ-025 WAIT_RESP counter reaching RESP_TIMEOUT SHALL pulse resp_timeout and return to IDLE; resp_strobe in that same cycle wins.
REQ-026 TURNAROUND: cmd_oe=1, cmd_out=1 for NCR cycles.
REQ-027 SEND short: bits 47..8 from resp_data[47:8], bits 7..1 computed CRC7, bit 0 forced 1; 48 cycles.
REQ-028 SEND long: resp_data[135:0] driven verbatim; 136 cycles.
REQ-029 DONE: cmd_oe=0, resp_done pulsed, next state IDLE; cmd_in ignored while cmd_oe=1.
REQ-030 resp_strobe outside WAIT_RESP SHALL be ignored and not acknowledged.
REQ-031 Bit counter SHALL be 8 bits, saturate-free, reloaded on each state entry.

Reset
REQ-032 On reset: state IDLE, cmd_oe=0, cmd_out=1, cmd_index=0, cmd_arg=0, all pulses 0, counters 0.
REQ-033 Reset mid-RECEIVE or mid-SEND SHALL abort; cmd_oe low from the cycle after reset is sampled.

Structure
REQ-034 Package sd_cmd_pkg SHALL hold frame lengths (48, 136), CRC7 polynomial, state encoding.
REQ-035 One sub-module sd_crc7 (serial CRC7, clear/enable/bit inputs), instanced for RX check and TX generation.

Verification
REQ-036 CMD0: 0x400000000095 on cmd_in -> cmd_valid, cmd_index=0, cmd_arg=0, crc_error=0.
REQ-037 CMD8: 0x48000001AA87 -> cmd_valid, cmd_index=8, cmd_arg=0x000001AA.
REQ-038 CMD8 with CRC byte 0x86 -> crc_error pulse, no cmd_valid, no cmd_oe, IDLE.
REQ-039 After CMD17, resp_strobe with resp_long=0, resp_data[47:8]=0x1100000900 -> resp_ack, 2 high cycles, 48 bits with CRC7 matching model, end bit 1, resp_done.
REQ-040 After CMD2, resp_long=1, resp_data=0x3F followed by 128 bits 0xA5... -> 136 bits verbatim, cmd_oe high 138 cycles total.
REQ-041 No resp_strobe 64 cycles after cmd_valid -> resp_timeout pulse, IDLE; reset asserted at SEND bit 20 -> cmd_oe=0 next cycle.
